// File: rtl/mdio_rd_ctrl.sv
// MDIO register read controller: IDLE -> RD (RD_LAT cycles) -> CAP -> ACK.
// Optional auto-increment pointer enabled by defining MDIO_RD_AUTOINC_EN.
module mdio_rd_ctrl #(
    parameter int unsigned RD_LAT = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        mdio_rd_start,
    input  logic        mdio_rd_next,
    input  logic [6:0]  mdio_rd_sel,
    input  logic [14:0] mdio_rd_addr,
    input  logic [8:0]  rf_mdio_pkt_data,
    output logic        mdio_read_en,
    output logic [6:0]  rf_mdio_data_sel,
    output logic [14:0] rf_mdio_memory_addr,
    output logic        mdio_rd_busy,
    output logic        mdio_rd_ack,
    output logic        mdio_rd_err,
    output logic [8:0]  mdio_rd_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_CAP  = 2'd2;
    localparam logic [1:0] S_ACK  = 2'd3;

    localparam logic [3:0] CNT_LOAD = 4'(RD_LAT - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [6:0]  sel_q,   sel_d;
    logic [14:0] addr_q,  addr_d;
    logic        err_q,   err_d;
    logic [8:0]  data_q,  data_d;

    logic        req;
    logic [14:0] req_addr;

`ifdef MDIO_RD_AUTOINC_EN
    // The latched address doubles as the pointer; start wins over next.
    always_comb begin
        req      = mdio_rd_start | mdio_rd_next;
        req_addr = mdio_rd_start ? mdio_rd_addr : addr_q + 15'd1;
    end
`else
    logic unused_next;
    assign unused_next = mdio_rd_next;

    always_comb begin
        req      = mdio_rd_start;
        req_addr = mdio_rd_addr;
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        err_d   = err_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                err_d = 1'b0;
                if (req) begin
                    if (mdio_rd_sel >= 7'd96) begin
                        err_d   = 1'b1;
                        data_d  = '0;
                        state_d = S_ACK;
                    end else begin
                        sel_d   = mdio_rd_sel;
                        addr_d  = req_addr;
                        cnt_d   = CNT_LOAD;
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_CAP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_CAP: begin
                data_d  = rf_mdio_pkt_data;
                state_d = S_ACK;
            end
            S_ACK: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    assign mdio_read_en        = (state_q == S_RD);
    assign mdio_rd_busy        = (state_q != S_IDLE);
    assign mdio_rd_ack         = (state_q == S_ACK);
    assign mdio_rd_err         = err_q;
    assign mdio_rd_data        = data_q;
    assign rf_mdio_data_sel    = sel_q;
    assign rf_mdio_memory_addr = addr_q;

endmodule
